// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath, ALU, register file and data memory (slave).
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       instr30;
  logic       zero;
  logic       mem_ready;

  logic [3:0] aluop;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_src;
  logic [1:0] wb_sel;
  logic       pc_we;
  logic       oldpc_we;
  logic       ir_we;
  logic       rf_we;
  logic       mem_re;
  logic       mem_we;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, instr30, zero, mem_ready,
    output aluop, alu_src_a, alu_src_b, pc_src, wb_sel,
           pc_we, oldpc_we, ir_we, rf_we, mem_re, mem_we, trap, state
  );

  modport slave (
    output opcode, funct3, instr30, zero, mem_ready,
    input  aluop, alu_src_a, alu_src_b, pc_src, wb_sel,
           pc_we, oldpc_we, ir_we, rf_we, mem_re, mem_we, trap, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-FSM control unit for the multi-cycle RV32I-subset CPU.
// Define ILLEGAL_TRAP_EN to park illegal instructions in TRAP; otherwise they are NOPs.
//
// state      | meaning
// IDLE       | after reset, nothing asserted
// FETCH      | load IR, save OLDPC, PC <= PC + 4
// DECODE     | ALUOUT <= OLDPC + IMM, dispatch on opcode
// EXEC_R     | A op B
// EXEC_I     | A + IMM
// EXEC_LUI   | pass IMM
// EXEC_AUIPC | OLDPC + IMM
// ALU_WB     | rd <= ALUOUT
// MEM_ADDR   | address A + IMM
// MEM_RD     | load request, wait for mem_ready
// MEM_WB     | rd <= MDR
// MEM_WR     | store request, wait for mem_ready
// BRANCH     | compare A/B, PC <= ALUOUT if taken
// JAL        | PC <= ALUOUT, rd <= PC
// JALR       | PC <= A + IMM, rd <= PC
// TRAP       | illegal instruction, held until reset
module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0010;
  localparam logic [3:0] ALU_NULL = 4'b1111;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH      = 4'd1,
    DECODE     = 4'd2,
    EXEC_R     = 4'd3,
    EXEC_I     = 4'd4,
    EXEC_LUI   = 4'd5,
    EXEC_AUIPC = 4'd6,
    ALU_WB     = 4'd7,
    MEM_ADDR   = 4'd8,
    MEM_RD     = 4'd9,
    MEM_WB     = 4'd10,
    MEM_WR     = 4'd11,
    BRANCH     = 4'd12,
    JAL        = 4'd13,
    JALR       = 4'd14,
    TRAP       = 4'd15
  } state_t;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t state_q, state_d, decode_next;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    decode_next = ILLEGAL_NEXT;
    case (bus.opcode)
      OP_R:     if (bus.funct3 == 3'b000) decode_next = EXEC_R;
      OP_I:     if (bus.funct3 == 3'b000) decode_next = EXEC_I;
      OP_LUI:   decode_next = EXEC_LUI;
      OP_AUIPC: decode_next = EXEC_AUIPC;
      OP_LOAD,
      OP_STORE: if (bus.funct3 == 3'b010) decode_next = MEM_ADDR;
      OP_BR:    if (bus.funct3[2:1] == 2'b00) decode_next = BRANCH;
      OP_JAL:   decode_next = JAL;
      OP_JALR:  decode_next = JALR;
      default:  decode_next = ILLEGAL_NEXT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = FETCH;
      FETCH:      state_d = DECODE;
      DECODE:     state_d = decode_next;
      EXEC_R,
      EXEC_I,
      EXEC_LUI,
      EXEC_AUIPC: state_d = ALU_WB;
      MEM_ADDR:   state_d = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:     if (bus.mem_ready) state_d = MEM_WB;
      MEM_WR:     if (bus.mem_ready) state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:       state_d = TRAP;
`endif
      default:    state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.aluop     = ALU_NULL;
    bus.alu_src_a = 2'b00;
    bus.alu_src_b = 2'b00;
    bus.pc_src    = 1'b0;
    bus.wb_sel    = 2'b00;
    bus.pc_we     = 1'b0;
    bus.oldpc_we  = 1'b0;
    bus.ir_we     = 1'b0;
    bus.rf_we     = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.trap      = 1'b0;
    case (state_q)
      FETCH: begin
        bus.ir_we     = 1'b1;
        bus.oldpc_we  = 1'b1;
        bus.pc_we     = 1'b1;
        bus.aluop     = ALU_ADD;
        bus.alu_src_b = 2'b10;
      end
      DECODE: begin
        bus.aluop     = ALU_ADD;
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      EXEC_R: begin
        bus.aluop     = bus.instr30 ? ALU_SUB : ALU_ADD;
        bus.alu_src_a = 2'b10;
      end
      EXEC_I, MEM_ADDR: begin
        bus.aluop     = ALU_ADD;
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      EXEC_LUI: begin
        bus.aluop     = ALU_PASS;
        bus.alu_src_b = 2'b01;
      end
      EXEC_AUIPC: begin
        bus.aluop     = ALU_ADD;
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      ALU_WB: bus.rf_we = 1'b1;
      MEM_RD: bus.mem_re = 1'b1;
      MEM_WB: begin
        bus.rf_we  = 1'b1;
        bus.wb_sel = 2'b01;
      end
      MEM_WR: bus.mem_we = 1'b1;
      // funct3[0] selects bne: taken when the operands differ
      BRANCH: begin
        bus.aluop     = ALU_SUB;
        bus.alu_src_a = 2'b10;
        bus.pc_src    = 1'b1;
        bus.pc_we     = bus.zero ^ bus.funct3[0];
      end
      JAL: begin
        bus.pc_we  = 1'b1;
        bus.pc_src = 1'b1;
        bus.rf_we  = 1'b1;
        bus.wb_sel = 2'b10;
      end
      JALR: begin
        bus.aluop     = ALU_ADD;
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.pc_we     = 1'b1;
        bus.rf_we     = 1'b1;
        bus.wb_sel    = 2'b10;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: bus.trap = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl; expected output vectors are hand-written per state.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // {state, aluop, src_a, src_b, pc_src, wb_sel, pc_we, oldpc_we, ir_we, rf_we, mem_re, mem_we, trap}
  localparam logic [21:0] E_IDLE    = {4'd0,  4'hF, 2'b00, 2'b00, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_FETCH   = {4'd1,  4'h0, 2'b00, 2'b10, 1'b0, 2'b00, 7'b1110000};
  localparam logic [21:0] E_DECODE  = {4'd2,  4'h0, 2'b01, 2'b01, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_EXR_ADD = {4'd3,  4'h0, 2'b10, 2'b00, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_EXR_SUB = {4'd3,  4'h1, 2'b10, 2'b00, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_EXI     = {4'd4,  4'h0, 2'b10, 2'b01, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_LUI     = {4'd5,  4'h2, 2'b00, 2'b01, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_AUIPC   = {4'd6,  4'h0, 2'b01, 2'b01, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_ALU_WB  = {4'd7,  4'hF, 2'b00, 2'b00, 1'b0, 2'b00, 7'b0001000};
  localparam logic [21:0] E_MADDR   = {4'd8,  4'h0, 2'b10, 2'b01, 1'b0, 2'b00, 7'b0000000};
  localparam logic [21:0] E_MRD     = {4'd9,  4'hF, 2'b00, 2'b00, 1'b0, 2'b00, 7'b0000100};
  localparam logic [21:0] E_MWB     = {4'd10, 4'hF, 2'b00, 2'b00, 1'b0, 2'b01, 7'b0001000};
  localparam logic [21:0] E_MWR     = {4'd11, 4'hF, 2'b00, 2'b00, 1'b0, 2'b00, 7'b0000010};
  localparam logic [21:0] E_BR_T    = {4'd12, 4'h1, 2'b10, 2'b00, 1'b1, 2'b00, 7'b1000000};
  localparam logic [21:0] E_BR_N    = {4'd12, 4'h1, 2'b10, 2'b00, 1'b1, 2'b00, 7'b0000000};
  localparam logic [21:0] E_JAL     = {4'd13, 4'hF, 2'b00, 2'b00, 1'b1, 2'b10, 7'b1001000};
  localparam logic [21:0] E_JALR    = {4'd14, 4'h0, 2'b10, 2'b01, 1'b0, 2'b10, 7'b1001000};
  localparam logic [21:0] E_TRAP    = {4'd15, 4'hF, 2'b00, 2'b00, 1'b0, 2'b00, 7'b0000001};

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_ADDI  = 32'h00108093;
  localparam logic [31:0] I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_JAL   = 32'h0080006F;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_LW    = 32'h0000A183;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  function automatic logic [21:0] obs();
    return {bus.state, bus.aluop, bus.alu_src_a, bus.alu_src_b, bus.pc_src, bus.wb_sel,
            bus.pc_we, bus.oldpc_we, bus.ir_we, bus.rf_we, bus.mem_re, bus.mem_we, bus.trap};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] i);
    bus.opcode  = i[6:0];
    bus.funct3  = i[14:12];
    bus.instr30 = i[30];
  endtask

  task automatic test_reset();
    logic [21:0] seq [5];
    seq = '{E_IDLE, E_FETCH, E_DECODE, E_EXR_ADD, E_ALU_WB};
    rst = 1'b1;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(I_ADD);
    step();
    step();
    rst = 1'b0;
    foreach (seq[i]) begin
      checks++;
      if (obs() !== seq[i]) begin
        errors++;
        $display("FAIL reset_add[%0d]: got %h expected %h", i, obs(), seq[i]);
      end
      step();
    end
  endtask

  task automatic test_alu_types();
    logic [31:0] ins [5];
    logic [21:0] ex  [5];
    logic [21:0] seq [4];
    ins = '{I_ADD, I_SUB, I_ADDI, I_LUI, I_AUIPC};
    ex  = '{E_EXR_ADD, E_EXR_SUB, E_EXI, E_LUI, E_AUIPC};
    foreach (ins[c]) begin
      set_instr(ins[c]);
      seq = '{E_FETCH, E_DECODE, ex[c], E_ALU_WB};
      foreach (seq[i]) begin
        checks++;
        if (obs() !== seq[i]) begin
          errors++;
          $display("FAIL alu_type%0d[%0d]: got %h expected %h", c, i, obs(), seq[i]);
        end
        step();
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [4];
    logic        zf  [4];
    logic [21:0] ex  [4];
    logic [21:0] seq [3];
    ins = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
    zf  = '{1'b1, 1'b0, 1'b0, 1'b1};
    ex  = '{E_BR_T, E_BR_N, E_BR_T, E_BR_N};
    foreach (ins[c]) begin
      set_instr(ins[c]);
      bus.zero = zf[c];
      seq = '{E_FETCH, E_DECODE, ex[c]};
      foreach (seq[i]) begin
        checks++;
        if (obs() !== seq[i]) begin
          errors++;
          $display("FAIL branch%0d[%0d]: got %h expected %h", c, i, obs(), seq[i]);
        end
        step();
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [31:0] ins [2];
    logic [21:0] ex  [2];
    logic [21:0] seq [3];
    ins = '{I_JAL, I_JALR};
    ex  = '{E_JAL, E_JALR};
    foreach (ins[c]) begin
      set_instr(ins[c]);
      seq = '{E_FETCH, E_DECODE, ex[c]};
      foreach (seq[i]) begin
        checks++;
        if (obs() !== seq[i]) begin
          errors++;
          $display("FAIL jump%0d[%0d]: got %h expected %h", c, i, obs(), seq[i]);
        end
        step();
      end
    end
  endtask

  // mem_ready is also raised outside MEM_RD, where it must be ignored
  task automatic test_load();
    logic [21:0] seq [8];
    logic        rdy [8];
    seq = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB};
    rdy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set_instr(I_LW);
    foreach (seq[i]) begin
      checks++;
      if (obs() !== seq[i]) begin
        errors++;
        $display("FAIL load[%0d]: got %h expected %h", i, obs(), seq[i]);
      end
      bus.mem_ready = rdy[i];
      step();
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_store();
    logic [21:0] seq [5];
    logic        rdy [5];
    seq = '{E_FETCH, E_DECODE, E_MADDR, E_MWR, E_MWR};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_instr(I_SW);
    foreach (seq[i]) begin
      checks++;
      if (obs() !== seq[i]) begin
        errors++;
        $display("FAIL store[%0d]: got %h expected %h", i, obs(), seq[i]);
      end
      bus.mem_ready = rdy[i];
      step();
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [21:0] seq [7];
    seq = '{E_FETCH, E_DECODE, E_MADDR, E_MWR, E_IDLE, E_FETCH, E_DECODE};
    set_instr(I_SW);
    foreach (seq[i]) begin
      checks++;
      if (obs() !== seq[i]) begin
        errors++;
        $display("FAIL reset_mid_write[%0d]: got %h expected %h", i, obs(), seq[i]);
      end
      rst = (i == 3);
      bus.mem_ready = (i >= 4);
      if (i == 5) set_instr(I_ADD);
      step();
    end
    // finish the add so the next test starts in FETCH
    bus.mem_ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    logic [21:0] seq [7];
    seq = '{E_FETCH, E_DECODE, E_TRAP, E_TRAP, E_TRAP, E_IDLE, E_FETCH};
`else
    logic [21:0] seq [3];
    seq = '{E_FETCH, E_DECODE, E_FETCH};
`endif
    set_instr(I_ILL);
    foreach (seq[i]) begin
      checks++;
      if (obs() !== seq[i]) begin
        errors++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, obs(), seq[i]);
      end
      bus.mem_ready = (i == 3);
      rst = (i == 4) && (seq[i] == E_TRAP);
      step();
    end
    rst = 1'b0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    bus.opcode    = 7'd0;
    bus.funct3    = 3'd0;
    bus.instr30   = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_alu_types();
    test_branch();
    test_jumps();
    test_load();
    test_store();
    test_reset_mid_write();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-FSM control unit for the multi-cycle RV32I-subset CPU.
- Drives the ALU's `aluop` and operand-select lines, and consumes the ALU `zero` flag to resolve branches.
- Sequences fetch, decode, execute, memory and writeback, handshaking with data memory.
- Sits between the instruction register / datapath and the ALU, register file and memories.

Parameters:
- ALU_ADD, 4'b0000, aluop code for add.
- ALU_SUB, 4'b0001, aluop code for subtract; ALU `zero` = operands equal.
- ALU_PASS, 4'b0010, aluop code for pass in1.
- ALU_NULL, 4'b1111, aluop code for idle; ALU outputs 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from IR.
- funct3  in  3  instr[14:12] from IR.
- instr30  in  1  instr[30] (funct7 bit 5) from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data-memory completion strobe.
- aluop  out  4  ALU operation.
- alu_src_a  out  2  00=PC, 01=OLDPC, 10=A.
- alu_src_b  out  2  00=B, 01=IMM, 10=const 4.
- pc_src  out  1  0=ALU result (combinational), 1=ALUOUT register.
- wb_sel  out  2  00=ALUOUT, 01=MDR, 10=PC.
- pc_we, oldpc_we, ir_we, rf_we  out  1 each  register write enables.
- mem_re, mem_we  out  1 each  data-memory request; held until mem_ready.
- trap  out  1  illegal-instruction flag.
- state  out  4  current state, for the debug unit.

Behaviour:
- Outputs are pure decodes of the state register. Unlisted outputs are 0; aluop defaults to ALU_NULL.
- State encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, EXEC_LUI 5, EXEC_AUIPC 6, ALU_WB 7, MEM_ADDR 8, MEM_RD 9, MEM_WB 10, MEM_WR 11, BRANCH 12, JAL 13, JALR 14, TRAP 15.
- rst=1 at an edge: state <= IDLE, trap <= 0. Applies from any state, including mid-MEM_RD/MEM_WR; outstanding requests are dropped. IDLE asserts nothing and goes to FETCH next cycle.
- FETCH: ir_we, oldpc_we, pc_we, aluop ADD, a=PC, b=4, pc_src=0. Next: DECODE.
- DECODE: aluop ADD, a=OLDPC, b=IMM (branch/jal target into ALUOUT). Dispatch on opcode:
  - 0110011 with funct3=000 → EXEC_R.
  - 0010011 with funct3=000 → EXEC_I.
  - 0110111 → EXEC_LUI.
  - 0010111 → EXEC_AUIPC.
  - 0000011 / 0100011 with funct3=010 → MEM_ADDR.
  - 1100011 with funct3 ∈ {000, 001} → BRANCH.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - Anything else is illegal (see Optional Feature).
- EXEC_R: a=A, b=B; aluop = instr30 ? SUB : ADD. Next: ALU_WB.
- EXEC_I: ADD, a=A, b=IMM. Next: ALU_WB.
- EXEC_LUI: PASS, b=IMM. Next: ALU_WB.
- EXEC_AUIPC: ADD, a=OLDPC, b=IMM. Next: ALU_WB.
- ALU_WB: rf_we, wb_sel=00. Next: FETCH.
- MEM_ADDR: ADD, a=A, b=IMM. Next: MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_re=1 held while mem_ready=0. On mem_ready=1 → MEM_WB; the datapath latches MDR on that edge.
- MEM_WB: rf_we, wb_sel=01. Next: FETCH.
- MEM_WR: mem_we=1 held until mem_ready=1. Next: FETCH.
- BRANCH: SUB, a=A, b=B, pc_src=1. pc_we = zero ^ funct3[0] (beq when funct3[0]=0, bne when 1). Next: FETCH.
- JAL: pc_we, pc_src=1, rf_we, wb_sel=10. PC already holds oldpc+4, so the link is correct. Next: FETCH.
- JALR: ADD, a=A, b=IMM, pc_we, pc_src=0, rf_we, wb_sel=10. The datapath clears bit 0 of the target. Next: FETCH.
- Cycle counts including FETCH:
  - ALU-type: 4.
  - BRANCH, JAL, JALR: 3.
  - Loads: 5 + wait cycles.
  - Stores: 4 + wait cycles.
- mem_ready outside MEM_RD/MEM_WR is ignored.

Optional Feature:
- ILLEGAL_TRAP_EN defined: illegal decode → TRAP. TRAP asserts trap=1 and no enables, and holds until rst.
- Undefined: illegal decode → FETCH (treated as NOP; PC already advanced); trap tied 0.

Test Plan:
- rst held 2 cycles, then released → state 0 for one cycle, then 1, then 2. aluop=1111 and all enables 0 during IDLE.
- add 0x002081B3 → states 1,2,3,7. aluop=0000 in EXEC_R; rf_we=1 only in ALU_WB. sub 0x402081B3 → aluop=0001 in EXEC_R.
- beq 0x00208463: zero=1 → pc_we=1, pc_src=1 in BRANCH. zero=0 → pc_we=0. bne (funct3=001) with zero=0 → pc_we=1.
- lw 0x0000A183 with mem_ready arriving 3 cycles after entering MEM_RD → mem_re=1 for 4 cycles, then MEM_WB with wb_sel=01, rf_we=1. Total 8 cycles.
- Illegal opcode 0x0000007F → with ILLEGAL_TRAP_EN: state 15, trap=1 until rst. Without it: next state 1, trap=0.
- rst pulsed during MEM_WR with mem_ready=0 → next state 0, mem_we=0 immediately. A later mem_ready has no effect.
